// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, FSM states and helpers for dmem_lat
// Purpose: load funct3 codes, store size codes, FSM state enum, counter width,
//          and the misalignment classifier used by the optional trap.
package dmem_pkg;

  localparam int LAT_W = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Unsupported funct3/size codes behave as word accesses, so they are
  // classified as words here too.
  function automatic logic dmem_misaligned(input logic       is_load,
                                           input logic [2:0] funct3,
                                           input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    logic is_half;
    logic is_word;
    if (is_load) begin
      is_half = (funct3 == F3_LH) || (funct3 == F3_LHU);
      is_word = !is_half && (funct3 != F3_LB) && (funct3 != F3_LBU);
    end else begin
      is_half = (size == SZ_H);
      is_word = (size != SZ_B) && (size != SZ_H);
    end
    return (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// rtl/dmem_lane.sv - byte-lane alignment and load extension logic
// Purpose: purely combinational lane steering shared by memory-side blocks.
// Ports:
//   i_funct3      load funct3 (LB/LH/LW/LBU/LHU, others act as LW)
//   i_size        store size (SB/SH/SW, 11 acts as SW)
//   i_addr_lo     byte address bits [1:0]
//   i_store_data  raw store data (low byte/half/word used)
//   i_word        addressed memory word
//   o_byte_en     per-byte write enables
//   o_store_word  store data replicated into every lane
//   o_load_data   extracted and extended load result
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_word,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_store_word,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load_data = i_word;
    case (i_funct3)
      F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_load_data = {24'h0, w_byte};
      F3_LHU:  o_load_data = {16'h0, w_half};
      default: o_load_data = i_word;
    endcase
  end

  // Data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    o_byte_en    = 4'b1111;
    o_store_word = i_store_data;
    case (i_size)
      SZ_B: begin
        o_byte_en    = 4'b0001 << i_addr_lo;
        o_store_word = {4{i_store_data[7:0]}};
      end
      SZ_H: begin
        o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_store_word = {2{i_store_data[15:0]}};
      end
      default: begin
        o_byte_en    = 4'b1111;
        o_store_word = i_store_data;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lat.sv
// rtl/dmem_lat.sv - latency-configurable data memory for the MA stage
// Purpose: accepts an encoded load/store, stalls the CPU for a programmable
//          latency, then performs the access. Optional macro
//          DMEM_MISALIGN_TRAP_EN suppresses misaligned accesses and flags them.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_dmem_read[3:0]    [3] load enable, [2:0] funct3
//   i_dmem_write[2:0]   [2] store enable, [1:0] size
//   i_dmem_addr         byte address
//   i_dmem_data_write   store data
//   o_dmem_data_read    registered, extended load result
//   o_busywait          stall request
//   o_misalign          one-cycle misaligned-access flag in DONE
module dmem_lat
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int READ_LAT    = 2,
  parameter int WRITE_LAT   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_dmem_read,
  input  logic [2:0]  i_dmem_write,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_data_write,
  output logic [31:0] o_dmem_data_read,
  output logic        o_busywait,
  output logic        o_misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] RD_CNT = LAT_W'(READ_LAT - 1);
  localparam logic [LAT_W-1:0] WR_CNT = LAT_W'(WRITE_LAT - 1);

  state_t           r_state;
  logic [LAT_W-1:0] r_cnt;
  logic             r_is_load;
  logic [2:0]       r_funct3;
  logic [1:0]       r_size;
  logic [AW+1:0]    r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_misalign;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic        w_req;
  logic        w_complete;
  logic        w_trap;
  logic        w_mem_we;
  logic [31:0] w_word;
  logic [31:0] w_load_data;
  logic [31:0] w_store_word;
  logic [3:0]  w_byte_en;
  logic        w_unused;

  assign w_req      = i_dmem_read[3] | i_dmem_write[2];
  assign w_complete = (r_state == ST_WAIT) && (r_cnt == '0);
  assign w_word     = r_mem[r_addr[AW+1:2]];
  assign w_unused   = &{1'b0, i_dmem_addr[31:AW+2]};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_trap = dmem_misaligned(r_is_load, r_funct3, r_size, r_addr[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  assign w_mem_we = w_complete && !r_is_load && !w_trap;

  // Stall is combinational in IDLE so the CPU holds in the request cycle itself.
  assign o_busywait       = (r_state == ST_IDLE) ? w_req : (r_state == ST_WAIT);
  assign o_dmem_data_read = r_rdata;
  assign o_misalign       = r_misalign;

  dmem_lane u_lane (
    .i_funct3     (r_funct3),
    .i_size       (r_size),
    .i_addr_lo    (r_addr[1:0]),
    .i_store_data (r_wdata),
    .i_word       (w_word),
    .o_byte_en    (w_byte_en),
    .o_store_word (w_store_word),
    .o_load_data  (w_load_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_is_load  <= 1'b0;
      r_funct3   <= '0;
      r_size     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            // Load wins when both enables are set; the store is dropped.
            r_is_load <= i_dmem_read[3];
            r_funct3  <= i_dmem_read[2:0];
            r_size    <= i_dmem_write[1:0];
            r_addr    <= i_dmem_addr[AW+1:0];
            r_wdata   <= i_dmem_data_write;
            r_cnt     <= i_dmem_read[3] ? RD_CNT : WR_CNT;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            if (r_is_load) begin
              r_rdata <= w_trap ? 32'h0 : w_load_data;
            end
            r_misalign <= w_trap;
            r_state    <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_misalign <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Storage has no reset; an asynchronous reset forces IDLE, which blocks
  // any in-flight store from reaching the array.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byte_en[b]) begin
          r_mem[r_addr[AW+1:2]][8*b +: 8] <= w_store_word[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_lat.sv
// tb/tb_dmem_lat.sv - scoreboard testbench for dmem_lat
module tb_dmem_lat;

  localparam int RL = 2;
  localparam int WL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  dmem_read;
  logic [2:0]  dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        busywait;
  logic        misalign;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    bit          chk;
    bit          mis;
    int          stall;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_val = 32'h0;
  bit          last_known = 1'b0;

  dmem_lat #(
    .DEPTH_WORDS (256),
    .READ_LAT    (RL),
    .WRITE_LAT   (WL)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_dmem_read       (dmem_read),
    .i_dmem_write      (dmem_write),
    .i_dmem_addr       (dmem_addr),
    .i_dmem_data_write (dmem_wdata),
    .o_dmem_data_read  (dmem_rdata),
    .o_busywait        (busywait),
    .o_misalign        (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a DONE cycle is a negedge with BUSYWAIT low after a run of highs.
  initial begin
    int   busy_run;
    exp_t e;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_run = 0;
      end else if (busywait) begin
        busy_run = busy_run + 1;
      end else if (busy_run > 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stall_len", busy_run, e.stall);
          check("misalign", {31'h0, misalign}, {31'h0, e.mis});
          if (e.chk) check(e.is_load ? "load_data" : "store_hold", dmem_rdata, e.data);
        end
        busy_run = 0;
      end
    end
  end

  task automatic idle_inputs();
    dmem_read  = 4'b0000;
    dmem_write = 3'b000;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (!busywait) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic req(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_load, input bit mis);
    exp_t e;
    e.is_load = rd[3];
    e.stall   = rd[3] ? RL + 1 : WL + 1;
    e.mis     = mis;
    if (rd[3]) begin
      e.data     = exp_load;
      e.chk      = 1'b1;
      last_val   = exp_load;
      last_known = 1'b1;
    end else begin
      e.data = last_val;
      e.chk  = last_known;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    dmem_read  = rd;
    dmem_write = wr;
    dmem_addr  = addr;
    dmem_wdata = wdata;
    wait_done();
    idle_inputs();
  endtask

  initial begin
    exp_t e0;
    idle_inputs();
    rst_n     = 1'b0;
    dmem_read = 4'b1010;
    dmem_addr = 32'h10;
    repeat (2) begin
      @(negedge clk);
      check("rst_busy", {31'h0, busywait}, 32'd1);
      check("rst_rdata", dmem_rdata, 32'h0);
      check("rst_misalign", {31'h0, misalign}, 32'd0);
    end
    // Storage is uninitialised, so only the timing of this load is checked.
    e0.is_load = 1'b1; e0.data = 32'h0; e0.chk = 1'b0; e0.mis = 1'b0; e0.stall = RL + 1;
    exp_q.push_back(e0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_done();
    idle_inputs();

    req(4'b0000, 3'b110, 32'h10, 32'h8000_F0A5, 32'h0,         1'b0); // SW
    req(4'b1010, 3'b000, 32'h10, 32'h0,         32'h8000_F0A5, 1'b0); // LW
    req(4'b1000, 3'b000, 32'h10, 32'h0,         32'hFFFF_FFA5, 1'b0); // LB
    req(4'b1100, 3'b000, 32'h10, 32'h0,         32'h0000_00A5, 1'b0); // LBU
    req(4'b1001, 3'b000, 32'h12, 32'h0,         32'hFFFF_8000, 1'b0); // LH
    req(4'b1101, 3'b000, 32'h12, 32'h0,         32'h0000_8000, 1'b0); // LHU
    req(4'b0000, 3'b100, 32'h11, 32'hFFFF_FF5A, 32'h0,         1'b0); // SB
    req(4'b1010, 3'b000, 32'h10, 32'h0,         32'h8000_5AA5, 1'b0); // LW
    req(4'b1000, 3'b000, 32'h13, 32'h0,         32'hFFFF_FF80, 1'b0); // LB top lane
    req(4'b1100, 3'b000, 32'h11, 32'h0,         32'h0000_005A, 1'b0); // LBU lane 1
    req(4'b0000, 3'b101, 32'h12, 32'hABCD_1234, 32'h0,         1'b0); // SH upper half
    req(4'b1011, 3'b000, 32'h10, 32'h0,         32'h1234_5AA5, 1'b0); // funct3 011 as LW
    req(4'b1010, 3'b110, 32'h10, 32'h0,         32'h1234_5AA5, 1'b0); // both: load wins
    req(4'b1010, 3'b000, 32'h10, 32'h0,         32'h1234_5AA5, 1'b0); // store was dropped

    // Reset during the WAIT of a store discards it.
    req(4'b0000, 3'b110, 32'h20, 32'h1111_1111, 32'h0,         1'b0);
    @(posedge clk);
    #1;
    dmem_write = 3'b110;
    dmem_addr  = 32'h20;
    dmem_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_busy", {31'h0, busywait}, 32'd0);
    end
    check("post_rst_rdata", dmem_rdata, 32'h0);
    last_val   = 32'h0;
    last_known = 1'b1;
    req(4'b1010, 3'b000, 32'h20, 32'h0,         32'h1111_1111, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
    req(4'b0000, 3'b101, 32'h21, 32'h0000_FFFF, 32'h0,         1'b1); // SH misaligned
    req(4'b1010, 3'b000, 32'h20, 32'h0,         32'h1111_1111, 1'b0);
    req(4'b1010, 3'b000, 32'h22, 32'h0,         32'h0,         1'b1); // LW misaligned
    req(4'b1001, 3'b000, 32'h11, 32'h0,         32'h0,         1'b1); // LH misaligned
`else
    req(4'b0000, 3'b101, 32'h21, 32'h0000_FFFF, 32'h0,         1'b0); // wraps to low half
    req(4'b1010, 3'b000, 32'h20, 32'h0,         32'h1111_FFFF, 1'b0);
    req(4'b1010, 3'b000, 32'h22, 32'h0,         32'h1111_FFFF, 1'b0);
    req(4'b1001, 3'b000, 32'h11, 32'h0,         32'h0000_5AA5, 1'b0);
`endif

    repeat (4) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
